bus_port_fifo: RTL
==================

Name: bus_port_fifo

Overview:
Per-device port adapter sitting directly between one device and one port of the bus arbiter/generator (bs_gnrtr_n_rbtr). The TX queue buffers device packets and presents them to the bus on pndng/D_pop, consuming on pop. The RX queue captures bus deliveries on push/D_push and hands them to the device. The top level instantiates one per bus port (drvrs instances), replacing the behavioural fifo_in model used by the bench drivers.

Parameters:
pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold destination ID.
depth, 8, entries per queue; power of two, >=2.
cnt_w, $clog2(depth)+1, occupancy counter width (derived, not overridable).

Ports:
clk  in  1  bus clock; all logic rising-edge.
reset  in  1  synchronous, active-high reset.
dev_wr  in  1  device write strobe into TX queue.
dev_wr_data  in  pckg_sz  device packet to send.
dev_full  out  1  TX queue full.
pndng  out  1  TX queue non-empty; to arbiter.
D_pop  out  pckg_sz  TX head packet; to arbiter.
pop  in  1  arbiter consumes TX head.
push  in  1  arbiter delivers packet.
D_push  in  pckg_sz  delivered packet.
dev_rd  in  1  device reads RX head.
dev_rd_data  out  pckg_sz  RX head packet.
dev_rx_valid  out  1  RX queue non-empty.
tx_count  out  cnt_w  TX occupancy.
rx_count  out  cnt_w  RX occupancy.
tx_drop_cnt  out  8  dropped device writes, saturating at 255.
rx_drop_cnt  out  8  dropped bus pushes, saturating at 255.

Behaviour:
- Clock is clk; reset is synchronous, active-high. While reset is high at a clk edge: pointers and counts go to 0, drop counters go to 0, pndng=0, dev_rx_valid=0, dev_full=0, D_pop=0, dev_rd_data=0. Reset mid-operation discards all queued packets; in-flight pop/push in that cycle are ignored.
- Both queues are first-word-fall-through. D_pop/dev_rd_data show the head combinationally from storage and are 0 when the queue is empty.
- Write latency: a packet written at edge N is visible on pndng/D_pop (TX) or dev_rx_valid/dev_rd_data (RX) after edge N. Zero bypass: an empty queue never forwards a same-cycle write.
- TX write: dev_wr accepted if not full, or if full and pop is high in the same cycle. Simultaneous accepted write and pop leave tx_count unchanged.
- TX write rejected (full, no pop): packet dropped, queue unchanged, tx_drop_cnt+1 saturating.
- pop while TX is empty: ignored, no state change, no error.
- RX push: same rules as TX write, mirrored. A full RX queue with dev_rd high accepts the push; otherwise the push is dropped and rx_drop_cnt increments.
- dev_rd while RX is empty: ignored.
- Pointers are log2(depth) bits and wrap naturally. Counts range 0..depth. Full is count==depth; empty is count==0.
- Outputs dev_full, pndng and dev_rx_valid are derived from the registered counts; no combinational path from pop/push to these flags.
- Packet contents pass through unmodified; no ID filtering. Routing is the arbiter's job.
- Order is strict FIFO per queue. TX and RX are fully independent.

Decomposition:
- Package bus_port_pkg: localparam defaults (PCKG_SZ=16, DEPTH=8, ID_W=8), typedef of the packet vector, function get_dest_id(pkt) returning the top ID_W bits, BROADCAST_ID=8'hFF.
- One sub-module, sync_fifo_fwft (pckg_sz, depth), instantiated twice (TX, RX). It carries wr, rd, wr_data, rd_data, count, full, empty, and a drop pulse. The top adds only the saturating drop counters and port mapping.

Test Plan:
- Reset: hold reset 5 cycles with dev_wr=1 and push=1 -> all outputs 0, counts 0, drop counters 0.
- TX order/latency: write 16'h0101, 16'h0202, 16'h0303 on consecutive cycles; pndng=1 the cycle after the first write, D_pop=16'h0101. Three pops return 0101, 0202, 0303, then pndng=0 and D_pop=0.
- TX full and drop: write 10 packets with no pop (depth 8) -> dev_full=1 after the 8th, tx_count=8, tx_drop_cnt=2. The 9th and 10th packets never appear on D_pop.
- Full with simultaneous write and pop: TX full, dev_wr with 16'hAAAA and pop in the same cycle -> tx_count stays 8, tx_drop_cnt unchanged, 16'hAAAA exits as the last of 8 pops.
- RX path plus wrap: push 20 packets 16'h0000..16'h0013, reading every cycle from the second on -> dev_rd_data order is exact across pointer wrap, rx_drop_cnt=0. Pop on empty TX and dev_rd on empty RX change nothing.
- Saturation and mid-run reset: 300 pushes to a full RX with no reads -> rx_drop_cnt=255. Assert reset for 1 cycle while both queues are non-empty -> next cycle counts=0 and flags=0.

Source files
------------

// File: rtl/bus_port_pkg.sv
// Shared types and defaults for the per-device bus port adapter.
package bus_port_pkg;

    localparam int PCKG_SZ = 16;
    localparam int DEPTH   = 8;
    localparam int ID_W    = 8;

    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

    typedef logic [PCKG_SZ-1:0] pkt_t;

    // Destination ID lives in the top ID_W bits of every packet.
    function automatic logic [ID_W-1:0] get_dest_id(input pkt_t pkt);
        return pkt[PCKG_SZ-1 -: ID_W];
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with a drop pulse for rejected
// writes. A full queue still accepts a write when a read happens in the
// same cycle. The head is shown straight from storage, and 0 when empty.
module sync_fifo_fwft
    import bus_port_pkg::*;
#(
    parameter  int pckg_sz = PCKG_SZ,
    parameter  int depth   = DEPTH,
    localparam int cnt_w   = $clog2(depth) + 1,
    localparam int ptr_w   = $clog2(depth)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [pckg_sz-1:0] wr_data,
    input  logic               rd,
    output logic [pckg_sz-1:0] rd_data,
    output logic [cnt_w-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               drop
);

    localparam logic [cnt_w-1:0] FULL_CNT = cnt_w'(depth);

    logic [pckg_sz-1:0] mem [depth];
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic               rd_ok;
    logic               wr_ok;

    // Flags come only from the registered count, never from rd/wr.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A read on an empty queue is ignored. A full queue takes a write only
    // when the head leaves in the same cycle.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);
    assign drop  = wr && full && !rd;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage write. Gated by reset so a write in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally (depth is a power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ptr_w'(1);
            if (rd_ok) rd_ptr <= rd_ptr + ptr_w'(1);
            count <= count + cnt_w'(wr_ok) - cnt_w'(rd_ok);
        end
    end

endmodule

// File: rtl/bus_port_fifo.sv
// Per-device bus port adapter. The TX queue feeds the arbiter on pndng/D_pop,
// and the RX queue captures arbiter deliveries for the device. Packets pass
// through untouched; routing is left to the arbiter.
module bus_port_fifo
    import bus_port_pkg::*;
#(
    parameter  int pckg_sz = PCKG_SZ,
    parameter  int depth   = DEPTH,
    localparam int cnt_w   = $clog2(depth) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dev_wr,
    input  logic [pckg_sz-1:0] dev_wr_data,
    output logic               dev_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               dev_rd,
    output logic [pckg_sz-1:0] dev_rd_data,
    output logic               dev_rx_valid,
    output logic [cnt_w-1:0]   tx_count,
    output logic [cnt_w-1:0]   rx_count,
    output logic [7:0]         tx_drop_cnt,
    output logic [7:0]         rx_drop_cnt
);

    logic tx_empty, tx_drop;
    logic rx_full, rx_empty, rx_drop;

    sync_fifo_fwft #(.pckg_sz(pckg_sz), .depth(depth)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .wr      (dev_wr),
        .wr_data (dev_wr_data),
        .rd      (pop),
        .rd_data (D_pop),
        .count   (tx_count),
        .full    (dev_full),
        .empty   (tx_empty),
        .drop    (tx_drop)
    );

    sync_fifo_fwft #(.pckg_sz(pckg_sz), .depth(depth)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .wr      (push),
        .wr_data (D_push),
        .rd      (dev_rd),
        .rd_data (dev_rd_data),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty),
        .drop    (rx_drop)
    );

    assign pndng        = !tx_empty;
    assign dev_rx_valid = !rx_empty;

    // Saturating count of device writes rejected by a full TX queue.
    always_ff @(posedge clk) begin
        if (reset)                                tx_drop_cnt <= '0;
        else if (tx_drop && tx_drop_cnt != 8'hFF) tx_drop_cnt <= tx_drop_cnt + 8'd1;
    end

    // Saturating count of bus pushes rejected by a full RX queue.
    always_ff @(posedge clk) begin
        if (reset)                                rx_drop_cnt <= '0;
        else if (rx_drop && rx_drop_cnt != 8'hFF) rx_drop_cnt <= rx_drop_cnt + 8'd1;
    end

endmodule
